// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants for the 1-to-4 registered demultiplexer
package demux_pkg;

    localparam int DEFAULT_WIDTH = 2;

    localparam logic [1:0] SEL_W = 2'b00;
    localparam logic [1:0] SEL_X = 2'b01;
    localparam logic [1:0] SEL_Y = 2'b10;
    localparam logic [1:0] SEL_Z = 2'b11;

endpackage

// File: rtl/demux_decode_2to4.sv
// rtl/demux_decode_2to4.sv - SEL/en to one-hot destination enable, all zero when disabled
module demux_decode_2to4
    import demux_pkg::*;
(
    input  logic       i_en,
    input  logic [1:0] i_sel,
    output logic [3:0] o_onehot
);

    always_comb begin
        o_onehot = 4'b0000;
        if (i_en) begin
            case (i_sel)
                SEL_W:   o_onehot = 4'b0001;
                SEL_X:   o_onehot = 4'b0010;
                SEL_Y:   o_onehot = 4'b0100;
                SEL_Z:   o_onehot = 4'b1000;
                default: o_onehot = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/demultiplexer.sv
// rtl/demultiplexer.sv - routes A to one of four registered outputs selected by SEL
module demultiplexer
    import demux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] A,
    input  logic [1:0]       SEL,
    output logic [WIDTH-1:0] W,
    output logic [WIDTH-1:0] X,
    output logic [WIDTH-1:0] Y,
    output logic [WIDTH-1:0] Z,
    output logic [3:0]       valid,
    output logic [1:0]       sel_q
);

    logic [3:0]       w_onehot;
    logic [WIDTH-1:0] r_w;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_z;
    logic [3:0]       r_valid;
    logic [1:0]       r_sel_q;

    demux_decode_2to4 u_decode (
        .i_en     (en),
        .i_sel    (SEL),
        .o_onehot (w_onehot)
    );

    // Unselected destinations are cleared every edge so only valid separates zero data from idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_w     <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_z     <= '0;
            r_valid <= '0;
            r_sel_q <= '0;
        end else begin
            r_w     <= w_onehot[0] ? A : '0;
            r_x     <= w_onehot[1] ? A : '0;
            r_y     <= w_onehot[2] ? A : '0;
            r_z     <= w_onehot[3] ? A : '0;
            r_valid <= w_onehot;
            if (en) begin
                r_sel_q <= SEL;
            end
        end
    end

    assign W     = r_w;
    assign X     = r_x;
    assign Y     = r_y;
    assign Z     = r_z;
    assign valid = r_valid;
    assign sel_q = r_sel_q;

endmodule

// File: tb/tb_demultiplexer.sv
// tb/tb_demultiplexer.sv - randomized self-checking bench for demultiplexer
module tb_demultiplexer;

    localparam int WIDTH = 2;

    logic             clk;
    logic             rst;
    logic             en;
    logic [WIDTH-1:0] A;
    logic [1:0]       SEL;
    logic [WIDTH-1:0] W;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Z;
    logic [3:0]       valid;
    logic [1:0]       sel_q;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] m_out [4];
    logic [3:0]       m_valid;
    logic [1:0]       m_selq;

    demultiplexer #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .A     (A),
        .SEL   (SEL),
        .W     (W),
        .X     (X),
        .Y     (Y),
        .Z     (Z),
        .valid (valid),
        .sel_q (sel_q)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_out[i] = '0;
        m_valid = 4'b0000;
        m_selq  = 2'b00;
    endtask

    // Destination index d receives the word; everything else reads zero.
    task automatic model_edge(input logic [WIDTH-1:0] a, input logic [1:0] s, input logic e);
        for (int i = 0; i < 4; i++) m_out[i] = (e && (i == int'(s))) ? a : '0;
        m_valid = e ? (4'b0001 << s) : 4'b0000;
        if (e) m_selq = s;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".W"}, 32'(W), 32'(m_out[0]));
        chk({tag, ".X"}, 32'(X), 32'(m_out[1]));
        chk({tag, ".Y"}, 32'(Y), 32'(m_out[2]));
        chk({tag, ".Z"}, 32'(Z), 32'(m_out[3]));
        chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
        chk({tag, ".sel_q"}, 32'(sel_q), 32'(m_selq));
    endtask

    // Called at a falling edge; the pre-check proves outputs ignore inputs until the next rising edge.
    task automatic cycle(input string tag, input logic [WIDTH-1:0] a, input logic [1:0] s, input logic e);
        A   = a;
        SEL = s;
        en  = e;
        #1;
        check_all({tag, ".pre"});
        @(posedge clk);
        model_edge(a, s, e);
        @(negedge clk);
        check_all({tag, ".post"});
    endtask

    task automatic rst_pulse(input string tag);
        rst = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        A   = 2'b11;
        SEL = 2'b10;
        model_reset();
        #1;
        check_all("reset_noclk");
        @(negedge clk);
        check_all("reset_held");
        rst = 1'b0;

        cycle("sweep0", 2'b00, 2'b00, 1'b1);
        cycle("sweep1", 2'b01, 2'b01, 1'b1);
        cycle("sweep2", 2'b01, 2'b10, 1'b1);
        cycle("sweep3", 2'b11, 2'b11, 1'b1);

        cycle("latency", 2'b10, 2'b01, 1'b1);

        cycle("en_lo_load", 2'b11, 2'b11, 1'b1);
        cycle("en_lo", 2'b01, 2'b00, 1'b0);
        cycle("en_lo2", 2'b10, 2'b10, 1'b0);

        cycle("mid_load", 2'b01, 2'b10, 1'b1);
        rst_pulse("mid_rst");
        cycle("after_rst", 2'b10, 2'b00, 1'b1);

        cycle("b2b0", 2'b11, 2'b00, 1'b1);
        cycle("b2b1", 2'b11, 2'b11, 1'b1);
        cycle("b2b2", 2'b11, 2'b00, 1'b1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 49) == 0) rst_pulse("rnd_rst");
            cycle("rnd", WIDTH'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
